// File: rtl/mips_fetch_unit_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Opcode constants are provided for benches and decode-side tooling.
package mips_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StFault = 2'd2
  } fetch_state_e;

  localparam int unsigned WordBytes = 4;

  localparam logic [5:0] OpBeq = 6'h04;
  localparam logic [5:0] OpBne = 6'h05;
  localparam logic [5:0] OpJ   = 6'h02;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC select (jump / taken branch / sequential) and
// program-window range check for the fetch stage.
module mips_next_pc
  import mips_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int unsigned MEMORY_DEPTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_plus_4_i,
  input  logic [25:0]           instr_idx_i,
  input  logic                  branch_eq_i,
  input  logic                  branch_ne_i,
  input  logic                  jump_i,
  input  logic                  zero_i,
  output logic [ADDR_WIDTH-1:0] next_pc_o,
  output logic                  in_range_o
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr    = RESET_VECTOR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   WindowBytes = (ADDR_WIDTH+1)'(MEMORY_DEPTH * WordBytes);

  logic [ADDR_WIDTH-1:0] w_jump_target;
  logic [ADDR_WIDTH-1:0] w_branch_offset;
  logic [ADDR_WIDTH-1:0] w_branch_target;
  logic [ADDR_WIDTH-1:0] w_rel_addr;
  logic                  w_taken;

  // Jump keeps the top region bits of pc+4 when the address is wider than 28 bits.
  if (ADDR_WIDTH > 28) begin : g_jump_region
    assign w_jump_target = {pc_plus_4_i[ADDR_WIDTH-1:28], instr_idx_i, 2'b00};
  end else begin : g_jump_flat
    assign w_jump_target = {instr_idx_i, 2'b00};
  end

  assign w_branch_offset = {{(ADDR_WIDTH-18){instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
  assign w_branch_target = pc_plus_4_i + w_branch_offset;
  assign w_taken         = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);

  always_comb begin
    next_pc_o = pc_plus_4_i;
    if (jump_i) begin
      next_pc_o = w_jump_target;
    end else if (w_taken) begin
      next_pc_o = w_branch_target;
    end
  end

  // Offset from the base wraps modulo 2^ADDR_WIDTH, so addresses below the base land far out.
  assign w_rel_addr = next_pc_o - BaseAddr;
  assign in_range_o = ({1'b0, w_rel_addr} < WindowBytes);

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack fetch from variable-latency memory,
// one-entry hold register, branch/jump resolution, sticky range fault.
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [31:0]           imem_data_i,
  output logic [31:0]           instr_o,
  output logic                  instr_valid_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus_4_o,
  input  logic                  stall_i,
  input  logic                  branch_eq_i,
  input  logic                  branch_ne_i,
  input  logic                  jump_i,
  input  logic                  zero_i,
  output logic                  fault_o,
  output logic [CNT_WIDTH-1:0]  retired_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = RESET_VECTOR[ADDR_WIDTH-1:0];

  fetch_state_e          r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
  logic [31:0]           r_instr, w_instr_next;
  logic [ADDR_WIDTH-1:0] r_instr_pc, w_instr_pc_next;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_next;

  logic [ADDR_WIDTH-1:0] w_pc_plus_4;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_in_range;

  assign w_pc_plus_4 = r_instr_pc + ADDR_WIDTH'(WordBytes);

  mips_next_pc #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RESET_VECTOR (RESET_VECTOR),
    .MEMORY_DEPTH (MEMORY_DEPTH)
  ) u_next_pc (
    .pc_plus_4_i (w_pc_plus_4),
    .instr_idx_i (r_instr[25:0]),
    .branch_eq_i (branch_eq_i),
    .branch_ne_i (branch_ne_i),
    .jump_i      (jump_i),
    .zero_i      (zero_i),
    .next_pc_o   (w_next_pc),
    .in_range_o  (w_in_range)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StFetch;
      r_pc       <= BaseAddr;
      r_instr    <= '0;
      r_instr_pc <= BaseAddr;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_cnt      <= w_cnt_next;
    end
  end

  // Branch/jump inputs only matter on the consume cycle of HOLD.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_cnt_next      = r_cnt;
    unique case (r_state)
      StFetch: begin
        if (imem_ack_i) begin
          w_instr_next    = imem_data_i;
          w_instr_pc_next = r_pc;
          w_state_next    = StHold;
        end
      end
      StHold: begin
        if (!stall_i) begin
          w_cnt_next   = r_cnt + CNT_WIDTH'(1);
          w_pc_next    = w_next_pc;
          w_state_next = w_in_range ? StFetch : StFault;
        end
      end
      StFault: begin
        w_state_next = StFault;
      end
      default: begin
        w_state_next = StFault;
      end
    endcase
  end

  // Request is gated by reset so it drops immediately on an asynchronous pulse.
  assign imem_req_o    = (r_state == StFetch) & ~reset;
  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign instr_valid_o = (r_state == StHold);
  assign instr_pc_o    = r_instr_pc;
  assign pc_plus_4_o   = w_pc_plus_4;
  assign fault_o       = (r_state == StFault);
  assign retired_cnt_o = r_cnt;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed cases plus randomized
// latency/stall/branch traffic checked every cycle against a behavioural model.
module tb_mips_fetch_unit;
  import mips_fetch_unit_pkg::*;

  localparam int unsigned AW    = 32;
  localparam logic [31:0] RV    = 32'h0;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_ack_i = 1'b0;
  logic [31:0]   imem_data_i = '0;
  logic [31:0]   instr_o;
  logic          instr_valid_o;
  logic [AW-1:0] instr_pc_o;
  logic [AW-1:0] pc_plus_4_o;
  logic          stall_i = 1'b0;
  logic          branch_eq_i = 1'b0;
  logic          branch_ne_i = 1'b0;
  logic          jump_i = 1'b0;
  logic          zero_i = 1'b0;
  logic          fault_o;
  logic [CW-1:0] retired_cnt_o;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .ADDR_WIDTH   (AW),
    .RESET_VECTOR (RV),
    .MEMORY_DEPTH (DEPTH),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_pc_o    (instr_pc_o),
    .pc_plus_4_o   (pc_plus_4_o),
    .stall_i       (stall_i),
    .branch_eq_i   (branch_eq_i),
    .branch_ne_i   (branch_ne_i),
    .jump_i        (jump_i),
    .zero_i        (zero_i),
    .fault_o       (fault_o),
    .retired_cnt_o (retired_cnt_o)
  );

  logic [31:0] mem [DEPTH];

  // Model: holding an instruction, faulted, current fetch PC, held word and its PC, count.
  bit          m_hold;
  bit          m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  int unsigned m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mnext(input logic [31:0] ipc, input logic [31:0] instr,
                                        input bit eq, input bit ne, input bit j, input bit z);
    logic [31:0] p4;
    int          imm;
    p4  = ipc + 32'd4;
    imm = int'($signed(instr[15:0]));
    if (j) return (p4 & 32'hF000_0000) | (32'(instr[25:0]) * 32'd4);
    if ((eq && z) || (ne && !z)) return p4 + 32'(imm * 4);
    return p4;
  endfunction

  function automatic bit minrange(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(RV)) && (la <= longint'(RV) + 4 * longint'(DEPTH) - 4);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - RV) >> 2;
    if (idx < DEPTH) return mem[idx];
    return $urandom;
  endfunction

  task automatic model_reset();
    m_hold  = 1'b0;
    m_fault = 1'b0;
    m_pc    = RV;
    m_instr = '0;
    m_ipc   = RV;
    m_cnt   = 0;
  endtask

  always begin
    @(posedge clk);
    #4;
    chk("req", 64'(imem_req_o), 64'(!reset && !m_hold && !m_fault));
    chk("addr", 64'(imem_addr_o), 64'(m_pc));
    chk("valid", 64'(instr_valid_o), 64'(m_hold));
    chk("fault", 64'(fault_o), 64'(m_fault));
    chk("count", 64'(retired_cnt_o), 64'(m_cnt));
    if (m_hold) begin
      chk("instr", 64'(instr_o), 64'(m_instr));
      chk("instr_pc", 64'(instr_pc_o), 64'(m_ipc));
      chk("pc_plus_4", 64'(pc_plus_4_o), 64'(m_ipc + 32'd4));
    end
  end

  // Called at a negedge; drives one cycle of inputs and advances the model at the edge.
  task automatic step(input bit ack, input bit stall, input bit eq, input bit ne, input bit j,
                      input bit z);
    logic [31:0] npc;
    imem_ack_i  = ack;
    imem_data_i = ack ? mem_rd(m_pc) : $urandom;
    stall_i     = stall;
    branch_eq_i = eq;
    branch_ne_i = ne;
    jump_i      = j;
    zero_i      = z;
    @(posedge clk);
    if (!m_fault) begin
      if (!m_hold) begin
        if (ack) begin
          m_instr = imem_data_i;
          m_ipc   = m_pc;
          m_hold  = 1'b1;
        end
      end else if (!stall) begin
        npc     = mnext(m_ipc, m_instr, eq, ne, j, z);
        m_cnt   = (m_cnt + 1) % (1 << CW);
        m_pc    = npc;
        m_hold  = 1'b0;
        m_fault = !minrange(npc);
      end
    end
    @(negedge clk);
  endtask

  task automatic fetch_hold();
    for (int k = 0; k < 8 && !m_hold; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    chk("fetch_bound", 64'(m_hold), 64'(1));
  endtask

  task automatic consume(input bit eq, input bit ne, input bit j, input bit z);
    step(1'b0, 1'b0, eq, ne, j, z);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int fault_cycles;
    model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = {6'h00, 10'h000, 16'(i)};
    mem[2] = {OpBeq, 5'd1, 5'd2, 16'hFFFE};
    mem[4] = {OpJ, 26'h5};

    // Hand-computed anchors for the model itself.
    chk("pin_beq_taken", 64'(mnext(32'h8, mem[2], 1, 0, 0, 1)), 64'h4);
    chk("pin_beq_not", 64'(mnext(32'h8, mem[2], 1, 0, 0, 0)), 64'hC);
    chk("pin_bne_taken", 64'(mnext(32'h8, mem[2], 0, 1, 0, 0)), 64'h4);
    chk("pin_jump", 64'(mnext(32'h10, mem[4], 1, 0, 1, 1)), 64'h14);
    chk("pin_range_hi", 64'(minrange(32'h1C)), 64'(1));
    chk("pin_range_out", 64'(minrange(32'h20)), 64'(0));

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req", 64'(imem_req_o), 64'(1));
    chk("rst_addr", 64'(imem_addr_o), 64'h0);
    chk("rst_valid", 64'(instr_valid_o), 64'(0));
    chk("rst_fault", 64'(fault_o), 64'(0));
    chk("rst_count", 64'(retired_cnt_o), 64'(0));

    // Sequential, beq taken back to 0x4.
    fetch_hold();
    chk("seq_pc0", 64'(instr_pc_o), 64'h0);
    consume(0, 0, 0, 0);
    chk("seq_addr4", 64'(imem_addr_o), 64'h4);
    fetch_hold(); consume(0, 0, 0, 0);
    chk("seq_addr8", 64'(imem_addr_o), 64'h8);
    fetch_hold();
    chk("beq_word", 64'(instr_o), 64'h1022FFFE);
    consume(1, 0, 0, 1);
    chk("beq_taken_addr", 64'(imem_addr_o), 64'h4);
    chk("count3", 64'(retired_cnt_o), 64'(3));
    fetch_hold(); consume(0, 0, 0, 0);
    fetch_hold(); consume(1, 0, 0, 0);
    chk("beq_not_addr", 64'(imem_addr_o), 64'hC);
    fetch_hold(); consume(0, 0, 0, 0);
    fetch_hold(); consume(1, 0, 1, 1);
    chk("jump_addr", 64'(imem_addr_o), 64'h14);

    // bne taken when zero clear.
    do_reset();
    fetch_hold(); consume(0, 0, 0, 0);
    fetch_hold(); consume(0, 0, 0, 0);
    fetch_hold(); consume(0, 1, 0, 0);
    chk("bne_taken_addr", 64'(imem_addr_o), 64'h4);

    // Latency of 3 cycles, then stall 2 cycles in HOLD with a taken branch presented.
    repeat (3) step(0, 1, 0, 0, 0, 0);
    chk("lat_req_held", 64'(imem_req_o), 64'(1));
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 1, 0, 1, 1);
    chk("stall_pc", 64'(instr_pc_o), 64'h4);
    chk("stall_count", 64'(retired_cnt_o), 64'(3));
    chk("stall_valid", 64'(instr_valid_o), 64'(1));
    consume(0, 0, 0, 0);
    chk("after_stall_addr", 64'(imem_addr_o), 64'h8);

    // Run sequentially off the end of the program window.
    for (int k = 0; k < 20 && !m_fault; k++) begin
      fetch_hold();
      consume(0, 0, 0, 0);
    end
    chk("oor_fault", 64'(fault_o), 64'(1));
    chk("oor_req", 64'(imem_req_o), 64'(0));
    chk("oor_addr", 64'(imem_addr_o), 64'h20);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    chk("oor_sticky", 64'(fault_o), 64'(1));
    do_reset();
    chk("oor_cleared_addr", 64'(imem_addr_o), 64'h0);

    // Asynchronous reset pulse in the middle of an outstanding fetch.
    fetch_hold(); consume(0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_req", 64'(imem_req_o), 64'(0));
    chk("async_addr", 64'(imem_addr_o), 64'h0);
    chk("async_count", 64'(retired_cnt_o), 64'(0));
    chk("async_valid", 64'(instr_valid_o), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    fetch_hold();
    chk("async_refetch_pc", 64'(instr_pc_o), 64'h0);

    // Randomized traffic with small branch offsets.
    for (int i = 0; i < int'(DEPTH); i++)
      mem[i] = {6'($urandom), 10'h000, 16'($urandom_range(0, 10) - 5)};
    fault_cycles = 0;
    for (int n = 0; n < 2000; n++) begin
      if (m_fault) begin
        fault_cycles++;
        if (fault_cycles > 3) begin
          fault_cycles = 0;
          do_reset();
        end
      end
      step(m_hold ? 1'($urandom) : ($urandom_range(0, 2) == 0),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 11) == 0,
           1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
